pong_board_renderer: RTL and testbench

Parametrised successor to the fixed Pong board drawer. It converts the VGA raster position into an 8-bit playfield pixel with configurable borders, a dashed centre net, and two seven-segment score digits. After a goal it flashes the border for a set number of frames. It sits between the VGA timing generator and the pixel mixer, and its output is OR-combined with the ball and paddle layers.

---
 rtl/pong_board_renderer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pong_board_renderer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_board_renderer.sv
// rtl/pong_board_renderer.sv - Pong playfield renderer: borders, dashed net, score digits, goal flash
//
// Converts the raster position into an 8-bit playfield colour. The result is
// meant to be OR-combined with the ball and paddle layers downstream.
//
// Ports:
//   clk      in   1  pixel clock, hcount/vcount advance once per cycle
//   rst      in   1  asynchronous active-high reset
//   hcount   in  11  raster column
//   vcount   in  10  raster row
//   score_l  in   4  left score, 0-9 drawn, 10-15 blank
//   score_r  in   4  right score, same encoding
//   goal     in   1  single-cycle pulse when a point is scored
//   pixel    out  8  registered pixel colour, 2 cycles after hcount/vcount
//   flashing out  1  high while the border flash is running

module pong_board_renderer #(
   parameter int         H_MAX        = 796,
   parameter int         V_MAX        = 599,
   parameter int         BORDER_T     = 1,
   parameter int         NET_X        = 400,
   parameter int         NET_W        = 1,
   parameter int         DASH_LEN     = 16,
   parameter int         SEG_T        = 4,
   parameter int         DIG_W        = 24,
   parameter int         DIG_Y        = 16,
   parameter int         DIG_LX       = 340,
   parameter int         DIG_RX       = 436,
   parameter int         FLASH_FRAMES = 60,
   parameter int         FLASH_HALF   = 8,
   parameter logic [7:0] FG_COLOR     = 8'hFF,
   parameter logic [7:0] FLASH_COLOR  = 8'hE0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [3:0]  score_l,
   input  logic [3:0]  score_r,
   input  logic        goal,
   output logic [7:0]  pixel,
   output logic        flashing
);

   localparam int DASH_BIT = $clog2(DASH_LEN);
   localparam int FRM_W    = $clog2(FLASH_FRAMES + 1);
   localparam int PH_W     = $clog2(FLASH_HALF + 1);
   localparam int BOX_H    = 2 * DIG_W;
   localparam int G_LO     = DIG_W - SEG_T / 2;
   localparam int G_HI     = DIG_W + SEG_T / 2;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Frame tick: edge-detect the origin so a held position fires once.
   // ------------------------------------------------------------------
   logic at_origin;
   logic origin_q;
   logic frame_tick;

   assign at_origin = (hcount == 11'd0) && (vcount == 10'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         origin_q   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         origin_q   <= at_origin;
         frame_tick <= at_origin & ~origin_q;
      end
   end

   // ------------------------------------------------------------------
   // Score sampling: only on frame_tick so a digit never tears mid-frame.
   // Reset value 4'hF draws blank.
   // ------------------------------------------------------------------
   logic [3:0] sc_l_q;
   logic [3:0] sc_r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc_l_q <= 4'hF;
         sc_r_q <= 4'hF;
      end else if (frame_tick) begin
         sc_l_q <= score_l;
         sc_r_q <= score_r;
      end
   end

   // ------------------------------------------------------------------
   // Flash FSM
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic              phase_q, phase_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         frm_q   <= '0;
         ph_q    <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         frm_q   <= frm_d;
         ph_q    <= ph_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      state_d = state_q;
      frm_d   = frm_q;
      ph_d    = ph_q;
      phase_d = phase_q;
      case (state_q)
         IDLE: begin
            if (goal) begin
               state_d = FLASH;
               frm_d   = FRM_W'(FLASH_FRAMES);
               ph_d    = PH_W'(FLASH_HALF);
               phase_d = 1'b1;
            end
         end
         FLASH: begin
            // A goal reload takes precedence over a coincident frame tick.
            if (goal) begin
               frm_d   = FRM_W'(FLASH_FRAMES);
               ph_d    = PH_W'(FLASH_HALF);
               phase_d = 1'b1;
            end else if (frame_tick) begin
               if (ph_q == PH_W'(1)) begin
                  ph_d    = PH_W'(FLASH_HALF);
                  phase_d = ~phase_q;
               end else begin
                  ph_d = ph_q - PH_W'(1);
               end
               if (frm_q == FRM_W'(1)) begin
                  state_d = IDLE;
                  frm_d   = '0;
                  ph_d    = '0;
                  phase_d = 1'b0;
               end else begin
                  frm_d = frm_q - FRM_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign flashing = (state_q == FLASH);

   // ------------------------------------------------------------------
   // Geometry
   // ------------------------------------------------------------------
   // Segment mask ordered {a,b,c,d,e,f,g}.
   function automatic logic [6:0] seg_decode(input logic [3:0] val);
      case (val)
         4'd0:    seg_decode = 7'b1111110;
         4'd1:    seg_decode = 7'b0110000;
         4'd2:    seg_decode = 7'b1101101;
         4'd3:    seg_decode = 7'b1111001;
         4'd4:    seg_decode = 7'b0110011;
         4'd5:    seg_decode = 7'b1011011;
         4'd6:    seg_decode = 7'b1011111;
         4'd7:    seg_decode = 7'b1110000;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1111011;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   // dx/dy are box-local and may be negative when left of / above the box.
   function automatic logic digit_hit(input int dx, input int dy, input logic [3:0] val);
      logic [6:0] m;
      logic       in_box;
      logic       left_col;
      logic       right_col;
      logic       upper;
      m         = seg_decode(val);
      in_box    = (dx >= 0) && (dx < DIG_W) && (dy >= 0) && (dy < BOX_H);
      left_col  = (dx < SEG_T);
      right_col = (dx >= DIG_W - SEG_T);
      upper     = (dy < DIG_W);
      digit_hit = in_box && (
                     (m[6] && (dy < SEG_T))              ||
                     (m[5] && right_col && upper)        ||
                     (m[4] && right_col && !upper)       ||
                     (m[3] && (dy >= BOX_H - SEG_T))     ||
                     (m[2] && left_col && !upper)        ||
                     (m[1] && left_col && upper)         ||
                     (m[0] && (dy >= G_LO) && (dy < G_HI)));
   endfunction

   int   h_i;
   int   v_i;
   logic valid_c;
   logic border_c;
   logic net_c;
   logic digit_c;
   logic flash_c;

   always_comb begin
      h_i      = int'(hcount);
      v_i      = int'(vcount);
      valid_c  = (h_i <= H_MAX) && (v_i <= V_MAX);
      border_c = (h_i < BORDER_T) || (v_i < BORDER_T) ||
                 (h_i > H_MAX - BORDER_T) || (v_i > V_MAX - BORDER_T);
      net_c    = (h_i >= NET_X) && (h_i < NET_X + NET_W) && !vcount[DASH_BIT];
      digit_c  = digit_hit(h_i - DIG_LX, v_i - DIG_Y, sc_l_q) ||
                 digit_hit(h_i - DIG_RX, v_i - DIG_Y, sc_r_q);
      // Colour choice travels with the pixel so a goal recolours only
      // pixels that enter the pipe after it.
      flash_c  = (state_q == FLASH) && phase_q;
   end

   // ------------------------------------------------------------------
   // Stage 1: region flags
   // ------------------------------------------------------------------
   logic s1_valid;
   logic s1_border;
   logic s1_net;
   logic s1_digit;
   logic s1_flash;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_border <= 1'b0;
         s1_net    <= 1'b0;
         s1_digit  <= 1'b0;
         s1_flash  <= 1'b0;
      end else begin
         s1_valid  <= valid_c;
         s1_border <= border_c;
         s1_net    <= net_c;
         s1_digit  <= digit_c;
         s1_flash  <= flash_c;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: colour, priority border > digit > net > black
   // ------------------------------------------------------------------
   logic [7:0] pix_d;

   always_comb begin
      pix_d = 8'h00;
      if (s1_valid) begin
         if (s1_border) begin
            pix_d = s1_flash ? FLASH_COLOR : FG_COLOR;
         end else if (s1_digit || s1_net) begin
            pix_d = FG_COLOR;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel <= 8'h00;
      end else begin
         pixel <= pix_d;
      end
   end

endmodule

// File: tb/tb_pong_board_renderer.sv
// tb/tb_pong_board_renderer.sv - self-checking bench for pong_board_renderer

module tb_pong_board_renderer;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic        goal;
   logic [7:0]  pixel;
   logic [7:0]  pixel3;
   logic        flashing;
   logic        flashing3;

   always #5 clk = ~clk;

   pong_board_renderer dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .score_l(score_l), .score_r(score_r), .goal(goal),
      .pixel(pixel), .flashing(flashing)
   );

   pong_board_renderer #(.H_MAX(639), .V_MAX(479), .BORDER_T(3)) dut3 (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .score_l(score_l), .score_r(score_r), .goal(goal),
      .pixel(pixel3), .flashing(flashing3)
   );

   typedef struct {
      int h;
      int v;
      bit g;
      int sl;
      int sr;
      int ea;
      int eb;
   } vec_t;

   typedef struct {
      int         h;
      int         v;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   int   n_vec = 0;
   int   n_err = 0;

   // reference model state
   int   m_sl, m_sr, m_k;
   bit   m_flashing, m_tick, m_prev_origin;
   exp_t pq[$];

   // last observation
   bit         have_pix;
   exp_t       cur;
   logic [7:0] obs_a, obs_b;
   logic       obs_fl, obs_fl3;
   bit         exp_fl;

   function automatic string seg_list(int d);
      case (d)
         0: return "abcdef";
         1: return "bc";
         2: return "abdeg";
         3: return "abcdg";
         4: return "bcfg";
         5: return "acdfg";
         6: return "acdefg";
         7: return "abc";
         8: return "abcdefg";
         default: return "abcdfg";
      endcase
   endfunction

   // 24x48 box, stroke 4
   function automatic bit seg_on(int dx, int dy, int d);
      string s;
      if (d > 9 || dx < 0 || dx >= 24 || dy < 0 || dy >= 48) return 1'b0;
      s = seg_list(d);
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "a": if (dy < 4) return 1'b1;
            "b": if (dx >= 20 && dy < 24) return 1'b1;
            "c": if (dx >= 20 && dy >= 24) return 1'b1;
            "d": if (dy >= 44) return 1'b1;
            "e": if (dx < 4 && dy >= 24) return 1'b1;
            "f": if (dx < 4 && dy < 24) return 1'b1;
            "g": if (dy >= 22 && dy < 26) return 1'b1;
            default: ;
         endcase
      end
      return 1'b0;
   endfunction

   function automatic logic [7:0] ref_pix(int h, int v, int bt, int hmax, int vmax,
                                          int sl, int sr, bit fon);
      if (h > hmax || v > vmax) return 8'h00;
      if (h < bt || v < bt || h > hmax - bt || v > vmax - bt) return fon ? 8'hE0 : 8'hFF;
      if (seg_on(h - 340, v - 16, sl) || seg_on(h - 436, v - 16, sr)) return 8'hFF;
      if (h == 400 && ((v / 16) % 2) == 0) return 8'hFF;
      return 8'h00;
   endfunction

   function automatic vec_t mk(int h, int v, bit g, int sl, int sr, int ea = -1, int eb = -1);
      vec_t x;
      x.h = h; x.v = v; x.g = g; x.sl = sl; x.sr = sr; x.ea = ea; x.eb = eb;
      return x;
   endfunction

   task automatic rand_xy(output int h, output int v);
      case ($urandom_range(0, 4))
         0: begin h = $urandom_range(0, 850); v = $urandom_range(0, 650); end
         1: begin h = $urandom_range(330, 470); v = $urandom_range(10, 70); end
         2: begin
            case ($urandom_range(0, 2))
               0: h = $urandom_range(0, 4);
               1: h = $urandom_range(634, 642);
               default: h = $urandom_range(792, 800);
            endcase
            v = $urandom_range(1, 620);
         end
         3: begin h = $urandom_range(398, 403); v = $urandom_range(0, 620); end
         default: begin
            h = $urandom_range(1, 820);
            case ($urandom_range(0, 2))
               0: v = $urandom_range(0, 4);
               1: v = $urandom_range(474, 482);
               default: v = $urandom_range(595, 602);
            endcase
         end
      endcase
   endtask

   task automatic model_reset();
      m_sl = 15; m_sr = 15; m_k = 0;
      m_flashing = 1'b0; m_tick = 1'b0; m_prev_origin = 1'b0;
      pq.delete();
   endtask

   // Called at a falling edge: sample, drive one vector, advance the model
   // across the next rising edge, then wait for the following falling edge.
   task automatic step(input vec_t vc);
      exp_t e;
      bit   fon;
      bit   org;
      obs_fl  = flashing;
      obs_fl3 = flashing3;
      exp_fl  = m_flashing;
      have_pix = 1'b0;
      if (pq.size() == 2) begin
         have_pix = 1'b1;
         obs_a = pixel;
         obs_b = pixel3;
         cur   = pq.pop_front();
      end
      hcount  = 11'(vc.h);
      vcount  = 10'(vc.v);
      goal    = vc.g;
      score_l = 4'(vc.sl);
      score_r = 4'(vc.sr);
      fon = m_flashing && (((m_k / 8) % 2) == 0);
      e.h = vc.h;
      e.v = vc.v;
      e.a = (vc.ea >= 0) ? 8'(vc.ea) : ref_pix(vc.h, vc.v, 1, 796, 599, m_sl, m_sr, fon);
      e.b = (vc.eb >= 0) ? 8'(vc.eb) : ref_pix(vc.h, vc.v, 3, 639, 479, m_sl, m_sr, fon);
      pq.push_back(e);
      if (vc.g) begin
         m_flashing = 1'b1;
         m_k = 0;
      end else if (m_tick && m_flashing) begin
         m_k++;
         if (m_k == 60) m_flashing = 1'b0;
      end
      if (m_tick) begin
         m_sl = vc.sl;
         m_sr = vc.sr;
      end
      org = (vc.h == 0 && vc.v == 0);
      m_tick = org && !m_prev_origin;
      m_prev_origin = org;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_vec += 4;
      if (pixel !== 8'h00) begin n_err++; $display("FAIL reset pixel got %h want 00", pixel); end
      if (pixel3 !== 8'h00) begin n_err++; $display("FAIL reset pixel3 got %h want 00", pixel3); end
      if (flashing !== 1'b0) begin n_err++; $display("FAIL reset flashing got %b want 0", flashing); end
      if (flashing3 !== 1'b0) begin n_err++; $display("FAIL reset flashing3 got %b want 0", flashing3); end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_border_defaults();
      vec_t vl[$];
      vl.push_back(mk(0, 0, 0, 15, 15, 8'hFF, 8'hFF));
      vl.push_back(mk(0, 300, 0, 15, 15, 8'hFF, 8'hFF));
      vl.push_back(mk(796, 300, 0, 15, 15, 8'hFF, 8'h00));
      vl.push_back(mk(400, 0, 0, 15, 15, 8'hFF, 8'hFF));
      vl.push_back(mk(400, 16, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(200, 300, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(797, 300, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(1, 300, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(795, 300, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(400, 32, 0, 15, 15, 8'hFF, 8'hFF));
      vl.push_back(mk(2, 100, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(3, 100, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(636, 100, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(637, 100, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(639, 100, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(640, 100, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(100, 2, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(100, 477, 0, 15, 15, 8'h00, 8'hFF));
      vl.push_back(mk(100, 480, 0, 15, 15, 8'h00, 8'h00));
      vl.push_back(mk(100, 599, 0, 15, 15, 8'hFF, 8'h00));
      vl.push_back(mk(100, 600, 0, 15, 15, 8'h00, 8'h00));
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL border pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL border pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
         n_vec += 2;
         if (obs_fl !== 1'b0) begin n_err++; $display("FAIL border flashing got %b want 0", obs_fl); end
         if (obs_fl3 !== 1'b0) begin n_err++; $display("FAIL border flashing3 got %b want 0", obs_fl3); end
      end
   endtask

   task automatic test_digits();
      vec_t vl[$];
      int   h, v, sl, sr;
      vl.push_back(mk(0, 0, 0, 8, 12));
      vl.push_back(mk(0, 300, 0, 8, 12));
      vl.push_back(mk(342, 18, 0, 8, 12, 8'hFF, 8'hFF));
      vl.push_back(mk(362, 40, 0, 8, 12, 8'hFF, 8'hFF));
      vl.push_back(mk(352, 30, 0, 8, 12, 8'h00, 8'h00));
      vl.push_back(mk(340, 16, 0, 8, 12, 8'hFF, 8'hFF));
      vl.push_back(mk(363, 63, 0, 8, 12, 8'hFF, 8'hFF));
      vl.push_back(mk(364, 30, 0, 8, 12, 8'h00, 8'h00));
      vl.push_back(mk(352, 39, 0, 8, 12, 8'hFF, 8'hFF));
      vl.push_back(mk(352, 42, 0, 8, 12, 8'h00, 8'h00));
      vl.push_back(mk(440, 20, 0, 8, 12, 8'h00, 8'h00));
      vl.push_back(mk(450, 60, 0, 8, 12, 8'h00, 8'h00));
      for (int f = 0; f < 10; f++) begin
         sl = $urandom_range(0, 15);
         sr = $urandom_range(0, 15);
         vl.push_back(mk(0, 0, 0, sl, sr));
         for (int j = 0; j < 30; j++) begin
            h = (j % 2 == 0) ? $urandom_range(338, 365) : $urandom_range(434, 461);
            v = $urandom_range(14, 66);
            vl.push_back(mk(h, v, 0, sl, sr));
         end
      end
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL digit pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL digit pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
      end
   endtask

   task automatic test_flash();
      vec_t vl[$];
      int   h, v;
      vl.push_back(mk(200, 300, 1, 3, 4));
      for (int f = 0; f < 64; f++) begin
         rand_xy(h, v);
         vl.push_back(mk(0, 0, 0, 3, 4));
         vl.push_back(mk(0, 300, 0, 3, 4));
         vl.push_back(mk(400, 32, 0, 3, 4));
         vl.push_back(mk(796, 300, 0, 3, 4));
         vl.push_back(mk(h, v, 0, 3, 4));
      end
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL flash pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL flash pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
         n_vec += 2;
         if (obs_fl !== exp_fl) begin n_err++; $display("FAIL flash flashing step %0d got %b want %b", i, obs_fl, exp_fl); end
         if (obs_fl3 !== exp_fl) begin n_err++; $display("FAIL flash flashing3 step %0d got %b want %b", i, obs_fl3, exp_fl); end
         if (i == 1) begin
            n_vec++;
            if (obs_fl !== 1'b1) begin n_err++; $display("FAIL flash rise got %b want 1", obs_fl); end
         end
      end
      n_vec++;
      if (obs_fl !== 1'b0) begin n_err++; $display("FAIL flash end got %b want 0", obs_fl); end
   endtask

   task automatic test_goal_restart();
      vec_t vl[$];
      int   h, v;
      for (int pass = 0; pass < 2; pass++) begin
         vl.push_back(mk(200, 300, 1, 5, 6));
         for (int f = 0; f < 30; f++) begin
            rand_xy(h, v);
            vl.push_back(mk(0, 0, 0, 5, 6));
            vl.push_back(mk(0, 300, 0, 5, 6));
            vl.push_back(mk(h, v, 0, 5, 6));
         end
         // pass 0: goal mid-frame; pass 1: goal on the frame_tick cycle
         vl.push_back(mk(0, 0, 0, 5, 6));
         vl.push_back(mk(0, 300, pass == 1, 5, 6));
         vl.push_back(mk(300, 400, pass == 0, 5, 6));
         for (int f = 0; f < 62; f++) begin
            rand_xy(h, v);
            vl.push_back(mk(0, 0, 0, 5, 6));
            vl.push_back(mk(796, 200, 0, 5, 6));
            vl.push_back(mk(h, v, 0, 5, 6));
         end
      end
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL restart pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL restart pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
         n_vec++;
         if (obs_fl !== exp_fl) begin n_err++; $display("FAIL restart flashing step %0d got %b want %b", i, obs_fl, exp_fl); end
      end
   endtask

   task automatic test_reset_mid_flash();
      vec_t vl[$];
      vl.push_back(mk(0, 0, 0, 8, 8));
      vl.push_back(mk(100, 300, 1, 8, 8));
      for (int f = 0; f < 3; f++) begin
         vl.push_back(mk(0, 0, 0, 8, 8));
         vl.push_back(mk(342, 18, 0, 8, 8));
         vl.push_back(mk(0, 300, 0, 8, 8));
      end
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec++;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL prereset pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
         end
      end
      #3 rst = 1'b1;
      #1;
      n_vec += 3;
      if (pixel !== 8'h00) begin n_err++; $display("FAIL midrst pixel got %h want 00", pixel); end
      if (pixel3 !== 8'h00) begin n_err++; $display("FAIL midrst pixel3 got %h want 00", pixel3); end
      if (flashing !== 1'b0) begin n_err++; $display("FAIL midrst flashing got %b want 0", flashing); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      vl.delete();
      vl.push_back(mk(342, 18, 0, 8, 8, 8'h00, 8'h00));
      vl.push_back(mk(362, 40, 0, 8, 8, 8'h00, 8'h00));
      vl.push_back(mk(0, 300, 0, 8, 8, 8'hFF, 8'hFF));
      vl.push_back(mk(0, 0, 0, 8, 8, 8'hFF, 8'hFF));
      vl.push_back(mk(342, 18, 0, 8, 8, 8'h00, 8'h00));
      vl.push_back(mk(342, 18, 0, 8, 8, 8'hFF, 8'hFF));
      vl.push_back(mk(362, 40, 0, 8, 8, 8'hFF, 8'hFF));
      vl.push_back(mk(200, 300, 0, 8, 8, 8'h00, 8'h00));
      vl.push_back(mk(200, 300, 0, 8, 8, 8'h00, 8'h00));
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL postrst pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL postrst pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
         n_vec++;
         if (obs_fl !== 1'b0) begin n_err++; $display("FAIL postrst flashing got %b want 0", obs_fl); end
      end
   endtask

   task automatic test_random();
      vec_t vl[$];
      int   h, v, sl, sr;
      sl = 0; sr = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0) begin
            sl = $urandom_range(0, 15);
            sr = $urandom_range(0, 15);
            vl.push_back(mk(0, 0, 0, sl, sr));
         end else begin
            rand_xy(h, v);
            vl.push_back(mk(h, v, ($urandom_range(0, 199) == 0), sl, sr));
         end
      end
      vl.push_back(mk(200, 300, 0, sl, sr));
      vl.push_back(mk(200, 300, 0, sl, sr));
      foreach (vl[i]) begin
         step(vl[i]);
         if (have_pix) begin
            n_vec += 2;
            if (obs_a !== cur.a) begin n_err++; $display("FAIL random pixel (%0d,%0d) got %h want %h", cur.h, cur.v, obs_a, cur.a); end
            if (obs_b !== cur.b) begin n_err++; $display("FAIL random pixel3 (%0d,%0d) got %h want %h", cur.h, cur.v, obs_b, cur.b); end
         end
         n_vec += 2;
         if (obs_fl !== exp_fl) begin n_err++; $display("FAIL random flashing step %0d got %b want %b", i, obs_fl, exp_fl); end
         if (obs_fl3 !== exp_fl) begin n_err++; $display("FAIL random flashing3 step %0d got %b want %b", i, obs_fl3, exp_fl); end
      end
   endtask

   initial begin
      rst     = 1'b1;
      hcount  = 11'd0;
      vcount  = 10'd0;
      goal    = 1'b0;
      score_l = 4'd0;
      score_r = 4'd0;
      repeat (2) @(negedge clk);
      test_reset();
      test_border_defaults();
      test_digits();
      test_flash();
      test_goal_restart();
      test_reset_mid_flash();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
